// File: rtl/comp_acc.sv
// comp_acc: complex accumulator behind the complex multiplier.
// Sums cfg_len consecutive {xr,yr} products into wide signed accumulators and emits one
// {xs,ys} sum per block. The sum register is decoupled from the accumulators, so the next
// block accumulates while the previous sum waits for the consumer.
// Optional feature: define COMP_ACC_SAT_EN to saturate each add on signed overflow;
// otherwise adds wrap modulo 2^AWIDTH. out_ovf flags either event within a block.
module comp_acc #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 24,
  parameter int unsigned CWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_rst,
  input  logic [CWIDTH-1:0]         cfg_len,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [4*(DWIDTH+1)-1:0]   in_data,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [2*AWIDTH-1:0]       out_data,
  output logic                      out_ovf
);

  localparam int unsigned FW = 2 * (DWIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [CWIDTH-1:0]   count_q, count_d;
  logic [CWIDTH-1:0]   len_q, len_d;
  logic                last_q, last_d;
  logic [AWIDTH-1:0]   acc_x_q, acc_x_d;
  logic [AWIDTH-1:0]   acc_y_q, acc_y_d;
  logic                ovf_q, ovf_d;
  logic                out_val_q, out_val_d;
  logic [2*AWIDTH-1:0] out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;

  logic                next_is_last;
  logic                accept;
  logic                complete;

  logic signed [FW-1:0] xr_s, yr_s;
  logic [AWIDTH-1:0]    xr_ext, yr_ext;
  logic [AWIDTH:0]      add_x, add_y;
  logic [CWIDTH-1:0]    len_eff, len_sel, count_inc;

  // Returns {overflow, result}; overflow when operands share a sign the result lacks.
  function automatic logic [AWIDTH:0] add_chk(input logic [AWIDTH-1:0] a,
                                              input logic [AWIDTH-1:0] b);
    logic [AWIDTH-1:0] sum;
    logic              ovf;
    sum = a + b;
    ovf = (a[AWIDTH-1] == b[AWIDTH-1]) && (sum[AWIDTH-1] != a[AWIDTH-1]);
`ifdef COMP_ACC_SAT_EN
    if (ovf) begin
      sum = a[AWIDTH-1] ? {1'b1, {(AWIDTH-1){1'b0}}} : {1'b0, {(AWIDTH-1){1'b1}}};
    end
`endif
    return {ovf, sum};
  endfunction

  assign xr_s      = in_data[2*FW-1:FW];
  assign yr_s      = in_data[FW-1:0];
  assign xr_ext    = AWIDTH'(xr_s);
  assign yr_ext    = AWIDTH'(yr_s);
  assign add_x     = add_chk(acc_x_q, xr_ext);
  assign add_y     = add_chk(acc_y_q, yr_ext);
  assign len_eff   = (cfg_len == '0) ? CWIDTH'(1) : cfg_len;
  // Length in force for this accept: live config on a block's first sample, latched after.
  assign len_sel   = (state_q == StIdle) ? len_eff : len_q;
  assign count_inc = count_q + CWIDTH'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (sw_rst) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept && !complete) state_d = StRun;
        StRun:   if (complete) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: ready only stalls the block's final sample while a sum is still pending.
  always_comb begin
    next_is_last = (state_q == StIdle) ? (cfg_len <= CWIDTH'(1)) : last_q;
    in_rdy       = ~(next_is_last & out_val_q);
    accept       = in_val & in_rdy;
    complete     = accept & next_is_last;
  end

  // Datapath next-state: accumulate, complete a block, and retire the pending sum.
  always_comb begin
    count_d    = count_q;
    len_d      = len_q;
    last_d     = last_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    ovf_d      = ovf_q;
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        out_data_d = {add_x[AWIDTH-1:0], add_y[AWIDTH-1:0]};
        out_ovf_d  = ovf_q | add_x[AWIDTH] | add_y[AWIDTH];
        out_val_d  = 1'b1;
        acc_x_d    = '0;
        acc_y_d    = '0;
        ovf_d      = 1'b0;
        count_d    = '0;
        last_d     = 1'b0;
      end else begin
        acc_x_d = add_x[AWIDTH-1:0];
        acc_y_d = add_y[AWIDTH-1:0];
        ovf_d   = ovf_q | add_x[AWIDTH] | add_y[AWIDTH];
        count_d = count_inc;
        len_d   = len_sel;
        last_d  = (count_inc == len_sel - CWIDTH'(1));
      end
    end

    if (sw_rst) begin
      count_d    = '0;
      len_d      = '0;
      last_d     = 1'b0;
      acc_x_d    = '0;
      acc_y_d    = '0;
      ovf_d      = 1'b0;
      out_val_d  = 1'b0;
      out_data_d = '0;
      out_ovf_d  = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      ovf_q      <= 1'b0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      len_q      <= len_d;
      last_q     <= last_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      ovf_q      <= ovf_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_comp_acc.sv
// Directed bench for comp_acc: default instance (AWIDTH=24) plus an AWIDTH=18 instance
// for the overflow case. Expected overflow result follows COMP_ACC_SAT_EN.
module tb_comp_acc;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int CW = 8;
  localparam int FW = 2 * (DW + 1);
  localparam int AW2 = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sw_rst = 1'b0;
  logic [CW-1:0]   cfg_len = '0;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [2*FW-1:0] in_data = '0;
  logic            out_val;
  logic            out_rdy = 1'b0;
  logic [2*AW-1:0] out_data;
  logic            out_ovf;

  logic [CW-1:0]    cfg_len2 = '0;
  logic             in_val2 = 1'b0;
  logic             in_rdy2;
  logic [2*FW-1:0]  in_data2 = '0;
  logic             out_val2;
  logic             out_rdy2 = 1'b0;
  logic [2*AW2-1:0] out_data2;
  logic             out_ovf2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comp_acc #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_rst   (sw_rst),
    .cfg_len  (cfg_len),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  comp_acc #(.DWIDTH(DW), .AWIDTH(AW2), .CWIDTH(CW)) dut18 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_rst   (sw_rst),
    .cfg_len  (cfg_len2),
    .in_val   (in_val2),
    .in_rdy   (in_rdy2),
    .in_data  (in_data2),
    .out_val  (out_val2),
    .out_rdy  (out_rdy2),
    .out_data (out_data2),
    .out_ovf  (out_ovf2)
  );

  function automatic logic [2*FW-1:0] pack_in(input int xr, input int yr);
    return {xr[FW-1:0], yr[FW-1:0]};
  endfunction

  function automatic logic [2*AW-1:0] pack_out(input int xs, input int ys);
    return {xs[AW-1:0], ys[AW-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int xs [3] = '{100, 200, -50};
    int ys [3] = '{-5, 10, 1};
    cfg_len = 8'd3;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_val  = 1'b1;
      in_data = pack_in(xs[i], ys[i]);
      @(negedge clk);
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL basic_in_rdy[%0d]: got %b want 1", i, in_rdy); end
      step();
      if (i < 2) begin
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_early_val[%0d]: got %b want 0", i, out_val); end
      end
    end
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_out_val: got %b want 1", out_val); end
    checks++; if (out_data !== pack_out(250, 6)) begin errors++; $display("FAIL basic_out_data: got %h want %h", out_data, pack_out(250, 6)); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_out_ovf: got %b want 0", out_ovf); end
    step();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_val_one_cycle: got %b want 0", out_val); end
  endtask

  task automatic test_len01();
    for (int l = 0; l < 2; l++) begin
      cfg_len = CW'(l);
      in_val  = 1'b1;
      in_data = pack_in(-7, 3);
      step();
      in_val = 1'b0;
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL len%0d_out_val: got %b want 1", l, out_val); end
      checks++; if (out_data !== pack_out(-7, 3)) begin errors++; $display("FAIL len%0d_out_data: got %h want %h", l, out_data, pack_out(-7, 3)); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL len%0d_out_ovf: got %b want 0", l, out_ovf); end
      step();
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL len%0d_val_drop: got %b want 0", l, out_val); end
    end
  endtask

  task automatic test_back_pressure();
    cfg_len = 8'd2;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_data = pack_in(1, 2);
    step();
    out_rdy = 1'b0;
    in_data = pack_in(3, 4);
    step();
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_blk1_val: got %b want 1", out_val); end
    checks++; if (out_data !== pack_out(4, 6)) begin errors++; $display("FAIL bp_blk1_data: got %h want %h", out_data, pack_out(4, 6)); end
    in_data = pack_in(10, 20);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_blk2_first_rdy: got %b want 1", in_rdy); end
    step();
    in_data = pack_in(30, 40);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall_rdy[%0d]: got %b want 0", c, in_rdy); end
      step();
      checks++; if (out_val !== 1'b1 || out_data !== pack_out(4, 6)) begin
        errors++; $display("FAIL bp_hold[%0d]: got val=%b data=%h want val=1 data=%h", c, out_val, out_data, pack_out(4, 6));
      end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_handshake_rdy: got %b want 0", in_rdy); end
    step();
    out_rdy = 1'b0;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bp_after_hs_val: got %b want 0", out_val); end
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b want 1", in_rdy); end
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_blk2_val: got %b want 1", out_val); end
    checks++; if (out_data !== pack_out(40, 60)) begin errors++; $display("FAIL bp_blk2_data: got %h want %h", out_data, pack_out(40, 60)); end
    out_rdy = 1'b1;
    step();
  endtask

  task automatic test_overflow();
    logic [AW2-1:0] exp_x;
`ifdef COMP_ACC_SAT_EN
    exp_x = 18'd131071;
`else
    exp_x = 18'd200000;  // -62144 in 18-bit two's complement
`endif
    cfg_len2 = 8'd2;
    out_rdy2 = 1'b1;
    in_val2  = 1'b1;
    in_data2 = pack_in(100000, 0);
    step();
    checks++; if (out_val2 !== 1'b0) begin errors++; $display("FAIL ovf_early_val: got %b want 0", out_val2); end
    step();
    in_val2 = 1'b0;
    checks++; if (out_val2 !== 1'b1) begin errors++; $display("FAIL ovf_out_val: got %b want 1", out_val2); end
    checks++; if (out_data2[2*AW2-1:AW2] !== exp_x) begin errors++; $display("FAIL ovf_xs: got %h want %h", out_data2[2*AW2-1:AW2], exp_x); end
    checks++; if (out_data2[AW2-1:0] !== '0) begin errors++; $display("FAIL ovf_ys: got %h want 0", out_data2[AW2-1:0]); end
    checks++; if (out_ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", out_ovf2); end
    step();
  endtask

  task automatic test_sw_rst();
    cfg_len = 8'd4;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_data = pack_in(5, 5);
    step();
    step();
    in_val = 1'b0;
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL swrst_no_out: got %b want 0", out_val); end
    in_val  = 1'b1;
    in_data = pack_in(1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL swrst_early_val[%0d]: got %b want 0", i, out_val); end
    end
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL swrst_out_val: got %b want 1", out_val); end
    checks++; if (out_data !== pack_out(4, 4)) begin errors++; $display("FAIL swrst_out_data: got %h want %h", out_data, pack_out(4, 4)); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL swrst_out_ovf: got %b want 0", out_ovf); end
    step();
  endtask

  task automatic test_async_reset();
    cfg_len = 8'd1;
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_data = pack_in(9, 9);
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL arst_pre_val: got %b want 1", out_val); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL arst_out_val: got %b want 0", out_val); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL arst_out_data: got %h want 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL arst_out_ovf: got %b want 0", out_ovf); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL arst_in_rdy: got %b want 1", in_rdy); end
    step();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len01();
    test_back_pressure();
    test_overflow();
    test_sw_rst();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
